// File: rtl/lab2_mem_stream_loader_pkg.sv
// rtl/lab2_mem_stream_loader_pkg.sv - shared constants, state type and helpers for the stream loader
package lab2_mem_stream_loader_pkg;

  localparam int DEPTH_DEF  = 8000;
  localparam int ADDR_W_DEF = 13;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_VERIFY,
    ST_VWAIT,
    ST_DONE
  } state_e;

  // Expand a 4-bit byte enable into a 32-bit per-byte data mask.
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/lab2_mem_stream_loader_if.sv
// rtl/lab2_mem_stream_loader_if.sv - byte stream and RAM bus interfaces for the stream loader
interface lab2_stream_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

interface lab2_mem_if
  import lab2_mem_stream_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       mem_readdata;

  modport master (
    output mem_address, output mem_byteenable, output mem_chipselect,
    output mem_write, output mem_writedata, output mem_clken,
    input  mem_readdata
  );
  modport slave (
    input  mem_address, input mem_byteenable, input mem_chipselect,
    input  mem_write, input mem_writedata, input mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/lab2_byte_packer.sv
// rtl/lab2_byte_packer.sv - packs accepted stream bytes little-endian into one 32-bit word
module lab2_byte_packer
  import lab2_mem_stream_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  input  logic        in_last_i,
  output logic        word_valid_o,
  output logic [31:0] word_o,
  output logic [3:0]  be_o,
  output logic        last_o
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  be_q, be_d;
  logic        last_q, last_d;
  logic        accept;

  assign accept = enable_i & in_valid_i;

  // Drop each accepted byte into the next lane; clear wins so a fresh word starts empty.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    be_d   = be_q;
    last_d = last_q;
    if (clear_i) begin
      idx_d  = 2'd0;
      word_d = '0;
      be_d   = BE_NONE;
      last_d = 1'b0;
    end else if (accept) begin
      word_d[8*idx_q +: 8] = in_data_i;
      be_d[idx_q]          = 1'b1;
      idx_d                = idx_q + 2'd1;
      last_d               = last_q | in_last_i;
    end
  end

  // Pack state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= 2'd0;
      word_q <= '0;
      be_q   <= BE_NONE;
      last_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
      be_q   <= be_d;
      last_q <= last_d;
    end
  end

  // A word is complete on the fourth lane or on the final stream byte.
  assign word_valid_o = accept & ((idx_q == 2'd3) | in_last_i);
  assign word_o       = word_q;
  assign be_o         = be_q;
  assign last_o       = last_q;

endmodule

// File: rtl/lab2_mem_stream_loader.sv
// rtl/lab2_mem_stream_loader.sv - stream-to-RAM loader with readback checksum verification
module lab2_mem_stream_loader
  import lab2_mem_stream_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  lab2_stream_if.slave      s_in,
  lab2_mem_if.master        mem,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              verify_ok,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, ptr_q, rptr_q;
  logic [ADDR_W:0]   wc_q;
  logic [31:0]       checksum_q, rd_sum_q, rd_sum_nxt;
  logic [3:0]        last_be_q;
  logic              overflow_q, verify_ok_q;
  logic              rd_valid_q, rd_last_q;

  logic              pk_word_valid, pk_last, pk_clear;
  logic [31:0]       pk_word;
  logic [3:0]        pk_be;
  logic              base_oob, rptr_at_end;

  assign base_oob    = {1'b0, base_addr} >= DEPTH_X;
  assign rptr_at_end = ({1'b0, rptr_q} + 1'b1) == ({1'b0, base_q} + wc_q);
  assign pk_clear    = ((state_q == ST_IDLE) && start) || (state_q == ST_WRITE);

  // Readback data lands one cycle after its address; the final word only counts its written lanes.
  assign rd_sum_nxt = rd_valid_q
                    ? rd_sum_q + (mem.mem_readdata & (rd_last_q ? be_to_mask(last_be_q) : 32'hFFFF_FFFF))
                    : rd_sum_q;

  lab2_byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (pk_clear),
    .enable_i     (state_q == ST_FILL),
    .in_data_i    (s_in.in_data),
    .in_valid_i   (s_in.in_valid),
    .in_last_i    (s_in.in_last),
    .word_valid_o (pk_word_valid),
    .word_o       (pk_word),
    .be_o         (pk_be),
    .last_o       (pk_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: fill/write loop, then readback, then a one-cycle done.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = base_oob ? ST_DONE : ST_FILL;
      ST_FILL:   if (pk_word_valid) state_d = ST_WRITE;
      ST_WRITE: begin
        if (pk_last)                 state_d = ST_VERIFY;
        else if (ptr_q == LAST_ADDR) state_d = ST_DONE;
        else                         state_d = ST_FILL;
      end
      ST_VERIFY: if (rptr_at_end) state_d = ST_VWAIT;
      ST_VWAIT:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Pointers, sums and result flags; results hold until the next accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q      <= '0;
      ptr_q       <= '0;
      rptr_q      <= '0;
      wc_q        <= '0;
      checksum_q  <= '0;
      rd_sum_q    <= '0;
      last_be_q   <= BE_FULL;
      overflow_q  <= 1'b0;
      verify_ok_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      rd_valid_q <= (state_q == ST_VERIFY);
      rd_last_q  <= (state_q == ST_VERIFY) && rptr_at_end;
      rd_sum_q   <= rd_sum_nxt;
      unique case (state_q)
        ST_IDLE: if (start) begin
          base_q      <= base_addr;
          ptr_q       <= base_addr;
          rptr_q      <= base_addr;
          wc_q        <= '0;
          checksum_q  <= '0;
          rd_sum_q    <= '0;
          overflow_q  <= base_oob;
          verify_ok_q <= 1'b0;
        end
        ST_WRITE: begin
          checksum_q <= checksum_q + pk_word;
          wc_q       <= wc_q + 1'b1;
          last_be_q  <= pk_be;
          if (pk_last)                 rptr_q     <= base_q;
          else if (ptr_q == LAST_ADDR) overflow_q <= 1'b1;
          else                         ptr_q      <= ptr_q + 1'b1;
        end
        ST_VERIFY: rptr_q <= rptr_q + 1'b1;
        ST_VWAIT:  verify_ok_q <= (rd_sum_nxt == checksum_q) && !overflow_q;
        default: ;
      endcase
    end
  end

  // Bus and status outputs decoded from the current state.
  always_comb begin
    s_in.in_ready      = 1'b0;
    mem.mem_address    = '0;
    mem.mem_byteenable = BE_FULL;
    mem.mem_chipselect = 1'b0;
    mem.mem_write      = 1'b0;
    mem.mem_writedata  = '0;
    mem.mem_clken      = 1'b1;
    busy               = (state_q != ST_IDLE);
    done               = (state_q == ST_DONE);
    unique case (state_q)
      ST_FILL: s_in.in_ready = 1'b1;
      ST_WRITE: begin
        mem.mem_chipselect = 1'b1;
        mem.mem_write      = 1'b1;
        mem.mem_address    = ptr_q;
        mem.mem_byteenable = pk_be;
        mem.mem_writedata  = pk_word;
      end
      ST_VERIFY: begin
        mem.mem_chipselect = 1'b1;
        mem.mem_address    = rptr_q;
      end
      default: ;
    endcase
  end

  assign overflow   = overflow_q;
  assign verify_ok  = verify_ok_q;
  assign word_count = wc_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_lab2_mem_stream_loader.sv
// tb/tb_lab2_mem_stream_loader.sv - self-checking bench for the stream loader
module tb_lab2_mem_stream_loader;

  typedef struct {
    logic [12:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [12:0] base_addr;
  logic        busy, done, overflow, verify_ok;
  logic [13:0] word_count;
  logic [31:0] checksum;

  lab2_stream_if s_if ();
  lab2_mem_if #(.ADDR_W(13)) m_if ();

  lab2_mem_stream_loader #(.DEPTH(8000), .ADDR_W(13)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .s_in       (s_if),
    .mem        (m_if),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .verify_ok  (verify_ok),
    .word_count (word_count),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:8191];
  logic        fill_en;
  logic [12:0] fill_addr;
  logic [31:0] fill_data;

  always @(posedge clk) begin
    if (fill_en) ram[fill_addr] <= fill_data;
    else if (m_if.mem_chipselect && m_if.mem_write) begin
      for (int b = 0; b < 4; b++)
        if (m_if.mem_byteenable[b]) ram[m_if.mem_address][8*b +: 8] <= m_if.mem_writedata[8*b +: 8];
    end
    if (m_if.mem_chipselect && !m_if.mem_write) m_if.mem_readdata <= ram[m_if.mem_address];
  end

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  stim [0:15];
  wr_t         exp_wr [$];
  logic [12:0] exp_rd [$];
  int          exp_wc, exp_consumed, done_cnt, done_lat;
  logic [31:0] exp_sum;
  logic        exp_ovf, exp_vok;
  bit          exp_active = 0;
  bit          done_flag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Expected behaviour from the load rules: consecutive 4-byte chunks, last chunk short on in_last,
  // stop with overflow after writing the top word of the RAM.
  task automatic build_model(input int base, input int n, input bit has_last);
    int pos, k, len;
    bit fin;
    logic [31:0] w;
    logic [3:0]  b;
    wr_t e;
    exp_wr.delete(); exp_rd.delete();
    exp_sum = 0; exp_wc = 0; exp_ovf = 0; exp_consumed = 0;
    if (base >= 8000) exp_ovf = 1;
    else begin
      pos = 0; k = 0;
      while (k < 8) begin
        fin = has_last && (n - pos <= 4);
        len = fin ? n - pos : 4;
        w = 0; b = 0;
        for (int j = 0; j < len; j++) begin
          w[8*j +: 8] = stim[pos + j];
          b[j] = 1'b1;
        end
        e.addr = 13'(base + k); e.data = w; e.be = b;
        exp_wr.push_back(e);
        exp_sum = exp_sum + w;
        exp_wc++;
        exp_consumed += len;
        if (fin) break;
        if (base + k == 7999) begin exp_ovf = 1; break; end
        k++; pos += 4;
      end
      if (!exp_ovf) for (int i = 0; i < exp_wc; i++) exp_rd.push_back(13'(base + i));
    end
    exp_vok = !exp_ovf;
  endtask

  // Per-cycle compare of every RAM access and of the done-cycle results against the model.
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (m_if.mem_chipselect && m_if.mem_write) begin
        chk("write_in_ready", 32'(s_if.in_ready), 0);
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual_addr=0x%h required=none", m_if.mem_address);
        end else begin
          e = exp_wr.pop_front();
          chk("write_addr", 32'(m_if.mem_address), 32'(e.addr));
          chk("write_data", m_if.mem_writedata, e.data);
          chk("write_be", 32'(m_if.mem_byteenable), 32'(e.be));
        end
      end
      if (m_if.mem_chipselect && !m_if.mem_write) begin
        chk("read_be", 32'(m_if.mem_byteenable), 32'hF);
        if (exp_rd.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read actual_addr=0x%h required=none", m_if.mem_address);
        end else chk("read_addr", 32'(m_if.mem_address), 32'(exp_rd.pop_front()));
      end
      if (done) begin
        done_cnt++;
        done_flag = 1;
        if (!exp_active) begin
          checks++; errors++;
          $display("FAIL spurious_done actual=1 required=0");
        end else begin
          chk("done_word_count", 32'(word_count), 32'(exp_wc));
          chk("done_checksum", checksum, exp_sum);
          chk("done_overflow", 32'(overflow), 32'(exp_ovf));
          chk("done_verify_ok", 32'(verify_ok), 32'(exp_vok));
        end
      end
    end
  end

  task automatic run_load(input int base, input int n, input bit has_last,
                          input bit gaps, input bit mid_start, input int abort_after);
    int sent, cyc;
    bit acc, hold;
    build_model(base, n, has_last);
    done_cnt = 0; done_flag = 0; exp_active = 1; done_lat = -1;
    @(posedge clk); #1;
    base_addr = 13'(base); start = 1;
    @(posedge clk); #1;
    start = 0;
    sent = 0; cyc = 0; hold = 0;
    while (!done_flag && cyc < 3000) begin
      if (abort_after > 0 && sent == abort_after) begin
        s_if.in_valid = 0; s_if.in_last = 0;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        exp_active = 0; exp_wr.delete(); exp_rd.delete();
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_write", 32'(m_if.mem_write), 0);
        chk("abort_chipselect", 32'(m_if.mem_chipselect), 0);
        @(negedge clk);
        chk("abort_write_next", 32'(m_if.mem_write), 0);
        return;
      end
      if (!hold) begin
        if (sent < n && (!gaps || (cyc % 2) == 0)) begin
          s_if.in_valid = 1; s_if.in_data = stim[sent]; s_if.in_last = has_last && (sent == n - 1);
        end else begin
          s_if.in_valid = 0; s_if.in_last = 0;
        end
      end
      start = mid_start && (cyc == 6);
      @(negedge clk);
      acc  = s_if.in_valid && s_if.in_ready;
      hold = s_if.in_valid && !s_if.in_ready;
      if (done && done_lat < 0) done_lat = cyc + 1;
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
    end
    s_if.in_valid = 0; s_if.in_last = 0; start = 0;
    if (!done_flag) begin
      checks++; errors++;
      $display("FAIL load_timeout actual=no_done required=done base=%0d", base);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done_pulses", 32'(done_cnt), 1);
    chk("bytes_accepted", 32'(sent), 32'(exp_consumed));
    chk("writes_outstanding", 32'(exp_wr.size()), 0);
    chk("reads_outstanding", 32'(exp_rd.size()), 0);
    chk("held_word_count", 32'(word_count), 32'(exp_wc));
    chk("held_checksum", checksum, exp_sum);
    chk("held_overflow", 32'(overflow), 32'(exp_ovf));
    chk("held_verify_ok", 32'(verify_ok), 32'(exp_vok));
    chk("idle_busy", 32'(busy), 0);
    chk("idle_in_ready", 32'(s_if.in_ready), 0);
    exp_active = 0;
  endtask

  task automatic prefill(input logic [12:0] a, input logic [31:0] d);
    fill_addr = a; fill_data = d; fill_en = 1;
    @(posedge clk); #1;
    fill_en = 0;
  endtask

  initial begin
    reset = 1; start = 0; base_addr = 0; fill_en = 0; fill_addr = 0; fill_data = 0;
    s_if.in_valid = 0; s_if.in_data = 0; s_if.in_last = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_verify_ok", 32'(verify_ok), 0);
    chk("rst_word_count", 32'(word_count), 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_byteenable", 32'(m_if.mem_byteenable), 32'hF);
    chk("rst_clken", 32'(m_if.mem_clken), 1);
    chk("rst_chipselect", 32'(m_if.mem_chipselect), 0);
    chk("rst_write", 32'(m_if.mem_write), 0);
    chk("rst_in_ready", 32'(s_if.in_ready), 0);
    @(posedge clk); #1;
    reset = 0;

    for (int i = 0; i < 8; i++) stim[i] = 8'(i + 1);
    build_model(16, 8, 1);
    chk("model_t1_w0", exp_wr[0].data, 32'h04030201);
    chk("model_t1_w1", exp_wr[1].data, 32'h08070605);
    chk("model_t1_sum", exp_sum, 32'h0C0A0806);
    run_load(16, 8, 1, 0, 0, 0);
    chk("t1_checksum", checksum, 32'h0C0A0806);
    chk("t1_word_count", 32'(word_count), 2);
    chk("t1_verify_ok", 32'(verify_ok), 1);
    chk("t1_ram_010", ram[16], 32'h04030201);
    chk("t1_ram_011", ram[17], 32'h08070605);

    prefill(13'h020, 32'hFFFF_FFFF);
    prefill(13'h021, 32'hFFFF_FFFF);
    stim[0] = 8'hAA; stim[1] = 8'hBB; stim[2] = 8'hCC; stim[3] = 8'hDD; stim[4] = 8'hEE;
    build_model(32, 5, 1);
    chk("model_t2_w1", exp_wr[1].data, 32'h000000EE);
    chk("model_t2_be1", 32'(exp_wr[1].be), 32'h1);
    run_load(32, 5, 1, 0, 0, 0);
    chk("t2_checksum", checksum, 32'hDDCCBC98);
    chk("t2_verify_ok", 32'(verify_ok), 1);
    chk("t2_ram_020", ram[32], 32'hDDCCBBAA);
    chk("t2_ram_021", ram[33], 32'hFFFFFFEE);

    for (int i = 0; i < 12; i++) stim[i] = 8'(8'h11 * (i + 1));
    run_load(7998, 12, 0, 0, 0, 0);
    chk("t3_overflow", 32'(overflow), 1);
    chk("t3_word_count", 32'(word_count), 2);
    chk("t3_verify_ok", 32'(verify_ok), 0);
    chk("t3_ram_7999", ram[7999], 32'h88776655);

    for (int i = 0; i < 8; i++) stim[i] = 8'(i + 1);
    run_load(48, 8, 1, 1, 1, 0);
    chk("t4_checksum", checksum, 32'h0C0A0806);
    chk("t4_ram_030", ram[48], 32'h04030201);
    chk("t4_ram_031", ram[49], 32'h08070605);

    run_load(64, 8, 1, 0, 0, 2);
    run_load(80, 8, 1, 0, 0, 0);
    chk("t5_checksum", checksum, 32'h0C0A0806);
    chk("t5_verify_ok", 32'(verify_ok), 1);

    run_load(8000, 4, 1, 0, 0, 0);
    chk("t6_done_latency_le2", 32'(done_lat > 0 && done_lat <= 2), 1);
    chk("t6_overflow", 32'(overflow), 1);
    chk("t6_word_count", 32'(word_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lab2_mem_stream_loader.md
Name: lab2_mem_stream_loader

Overview:
Avalon-MM write master that sits directly upstream of the 8000x32 single-port on-chip program/data RAM. It accepts a byte stream (valid/ready), packs the bytes little-endian into 32-bit words, and writes them to consecutive word addresses starting at a programmed base. After the load it reads the written range back, checksums the readback and flags any mismatch. It is used to load application images or data buffers into on-chip memory without involving the CPU.

Parameters:
DEPTH, 8000, number of 32-bit words in the target RAM; the last valid word address is DEPTH-1
ADDR_W, 13, word-address width; must satisfy 2**ADDR_W >= DEPTH
Data width is fixed at 32 bits (4 byte lanes); it is not a parameter.

Ports:
clk  in  1  single clock domain, shared with the RAM
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a load; honoured only in IDLE
base_addr  in  ADDR_W  first word address; sampled on start
in_data  in  8  stream byte
in_valid  in  1  in_data is valid
in_last  in  1  marks the final byte; qualified by in_valid
in_ready  out  1  loader accepts the byte in this cycle
mem_address  out  ADDR_W  word address to the RAM
mem_byteenable  out  4  byte lanes for a write; 4'hF on reads
mem_chipselect  out  1  RAM access strobe
mem_write  out  1  write strobe
mem_writedata  out  32  packed write word
mem_clken  out  1  RAM clock enable; tied to 1
mem_readdata  in  32  RAM read data; valid 1 cycle after a read address is presented
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at the end of a load
overflow  out  1  the load ran past DEPTH-1; held until the next start
verify_ok  out  1  readback checksum equals the write checksum; held until the next start
word_count  out  ADDR_W+1  number of words written; held until the next start
checksum  out  32  write checksum, sum of written words modulo 2**32; held until the next start

Behaviour:
- Reset values: all outputs 0 except mem_byteenable = 4'hF and mem_clken = 1. State is IDLE.
- Reset in any state aborts the load. No write strobe is issued in the cycle after reset.
- States: IDLE, FILL, WRITE, VERIFY, VWAIT, DONE.
- IDLE: on start, latch base_addr into ptr, clear lane index, pack register, sums, word_count, overflow and verify_ok.
  - If base_addr >= DEPTH: set overflow and go to DONE. No memory access occurs.
  - Otherwise go to FILL. start is ignored in every state except IDLE.
- FILL: in_ready = 1.
  - On in_valid & in_ready, the byte goes to lane[idx] and idx increments.
  - Go to WRITE when idx reaches 3, or on in_last. byteenable = lanes filled so far (4'b0001, 0011, 0111 or 1111). Unfilled lanes are 0.
  - Gaps in in_valid simply wait in FILL.
- WRITE: exactly one cycle with mem_chipselect = mem_write = 1, mem_address = ptr and in_ready = 0.
  - checksum += writedata; word_count++; remember byteenable as last_be.
  - If the last byte was seen: go to VERIFY with rptr = base.
  - Else if ptr == DEPTH-1: set overflow and go to DONE. Remaining stream bytes are not accepted.
  - Else: ptr++ and go to FILL, with idx and pack register cleared.
- VERIFY: one read per cycle (chipselect = 1, write = 0) at rptr = base .. base+word_count-1.
  - The data returned in the following cycle is added to rd_sum. The final word is masked by last_be expanded per byte.
  - After the last address is issued, go to VWAIT.
- VWAIT: one cycle to capture the last readdata, then go to DONE.
- DONE: one cycle. done = 1. verify_ok = (rd_sum == checksum), or 0 if overflow is set. Then go to IDLE.
- in_ready is 0 outside FILL. A byte presented during WRITE is held by the source, per the valid/ready rule.
- All sums are 32-bit and wrap.

Decomposition:
- Shared package: DEPTH/ADDR_W defaults, the state enumeration, and the 4-bit byteenable constants (BE_FULL = 4'hF).
- One sub-module: lab2_byte_packer. It owns the lane index, pack register and byteenable generation, and emits word_valid/word/be/last.
- The top level owns the FSM, address pointers and checksums.

Test Plan:
- base 0x010; bytes 01..08, last on 08 -> writes 0x010 = 0x04030201 be F and 0x011 = 0x08070605 be F; word_count 2; checksum 0x0C0A0806; verify_ok 1; done pulses once.
- base 0x020; bytes AA BB CC DD EE (last on EE); RAM pre-filled with 0xFFFFFFFF -> 0x021 = 0x000000EE be 0001; checksum 0xDDCCBC98; masked readback matches; verify_ok 1.
- base 7998; 12 bytes, no last -> writes at 7998 and 7999 only; overflow 1; word_count 2; verify_ok 0; in_ready stays 0 after byte 8.
- in_valid toggling every other cycle, plus a start pulse mid-load -> data identical to the gap-free case; the mid-load start is ignored; in_ready is 0 in every WRITE cycle.
- Reset asserted during FILL after 2 bytes -> next cycle busy 0 and no mem_write; a fresh load then behaves normally.
- base_addr 8000 -> no chipselect; done and overflow assert within 2 cycles of start.
